// File: rtl/AMITypes.sv
// Shared AMI memory-port types and default queue sizing.
package AMITypes;

   localparam int AMI_ADDR_WIDTH              = 64;
   localparam int AMI_DATA_WIDTH              = 512;
   localparam int AMI_PORT_BUF_LOG_Q_DEFAULT  = 3;

   typedef struct packed {
      logic                      valid;
      logic                      isWrite;
      logic [AMI_ADDR_WIDTH-1:0] addr;
      logic [AMI_DATA_WIDTH-1:0] data;
   } MemReq;

   typedef struct packed {
      logic                      valid;
      logic [AMI_DATA_WIDTH-1:0] data;
   } MemResp;

   // Request queue entries drop the valid bit; isWrite sits in the MSB.
   localparam int MEM_REQ_Q_W = $bits(MemReq) - 1;

   function automatic logic [MEM_REQ_Q_W-1:0] req_pack(input MemReq r);
      return {r.isWrite, r.addr, r.data};
   endfunction

endpackage

// File: rtl/ami_port_fifo.sv
// Synchronous FIFO with LOG_DEPTH+1 bit wrapping pointers; push/pop are ignored when full/empty.
module ami_port_fifo #(
   parameter int WIDTH     = 8,
   parameter int LOG_DEPTH = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head,
   output logic                 full,
   output logic                 empty,
   output logic [LOG_DEPTH:0]   count
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam logic [LOG_DEPTH:0] PTR_ONE = 1;

   logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];
   logic               do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                 (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
      count    = wr_ptr_q - rd_ptr_q;
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      head     = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: empty pointers hide stale entries.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= push_data;
   end

endmodule

// File: rtl/ami_port_buffer.sv
// Per-port elastic buffer in front of AmorphOSMem: request FIFO, credit-gated reads, response FIFO.
// Define AMI_PORT_BUFFER_STATS_EN to compile in the stat_wr/stat_rd/stat_resp counters.
module ami_port_buffer
   import AMITypes::*;
#(
   parameter int LOG_REQ_Q_SIZE  = AMI_PORT_BUF_LOG_Q_DEFAULT,
   parameter int LOG_RESP_Q_SIZE = AMI_PORT_BUF_LOG_Q_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  MemReq                    app_req_in,
   output logic                     app_req_grant_out,
   output MemResp                   app_resp_out,
   input  logic                     app_resp_grant_in,
   output MemReq                    ami_req_out,
   input  logic                     ami_req_grant_in,
   input  MemResp                   ami_resp_in,
   output logic                     ami_resp_grant_out,
   output logic [LOG_REQ_Q_SIZE:0]  req_q_count,
   output logic [LOG_RESP_Q_SIZE:0] read_credits,
   output logic [31:0]              stat_wr,
   output logic [31:0]              stat_rd,
   output logic [31:0]              stat_resp
);

   localparam logic [LOG_RESP_Q_SIZE:0] CREDIT_MAX = {1'b1, {LOG_RESP_Q_SIZE{1'b0}}};
   localparam logic [LOG_RESP_Q_SIZE:0] CREDIT_ONE = 1;

   logic [MEM_REQ_Q_W-1:0]     req_head;
   logic                       req_full, req_empty;
   logic [AMI_DATA_WIDTH-1:0]  resp_head;
   logic                       resp_full, resp_empty;
   logic [LOG_RESP_Q_SIZE:0]   resp_count_unused;
   logic [LOG_RESP_Q_SIZE:0]   credits_q, credits_d;
   logic                       ami_req_vld, req_issue, rd_issue, resp_pop;

   ami_port_fifo #(.WIDTH(MEM_REQ_Q_W), .LOG_DEPTH(LOG_REQ_Q_SIZE)) u_req_q (
      .clk       (clk),
      .rst       (rst),
      .push      (app_req_grant_out),
      .push_data (req_pack(app_req_in)),
      .pop       (req_issue),
      .head      (req_head),
      .full      (req_full),
      .empty     (req_empty),
      .count     (req_q_count)
   );

   ami_port_fifo #(.WIDTH(AMI_DATA_WIDTH), .LOG_DEPTH(LOG_RESP_Q_SIZE)) u_resp_q (
      .clk       (clk),
      .rst       (rst),
      .push      (ami_resp_grant_out),
      .push_data (ami_resp_in.data),
      .pop       (resp_pop),
      .head      (resp_head),
      .full      (resp_full),
      .empty     (resp_empty),
      .count     (resp_count_unused)
   );

   // Grants are held low during reset so nothing is acknowledged and then discarded.
   always_comb begin
      app_req_grant_out  = ~rst & app_req_in.valid & enable & ~req_full;
      ami_resp_grant_out = ~rst & ami_resp_in.valid & ~resp_full;
      ami_req_vld        = enable & ~req_empty & (req_head[MEM_REQ_Q_W-1] | (credits_q != '0));
      ami_req_out        = {ami_req_vld, req_head};
      req_issue          = ami_req_vld & ami_req_grant_in;
      rd_issue           = req_issue & ~req_head[MEM_REQ_Q_W-1];
      app_resp_out.valid = ~resp_empty;
      app_resp_out.data  = resp_head;
      resp_pop           = app_resp_grant_in & ~resp_empty;
      read_credits       = credits_q;
   end

   // A read reserves a response slot when issued; the slot returns when the app pops it.
   always_comb begin
      credits_d = credits_q;
      if (rd_issue && !resp_pop)
         credits_d = credits_q - CREDIT_ONE;
      else if (resp_pop && !rd_issue && credits_q != CREDIT_MAX)
         credits_d = credits_q + CREDIT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) credits_q <= CREDIT_MAX;
      else     credits_q <= credits_d;
   end

`ifdef AMI_PORT_BUFFER_STATS_EN
   logic [31:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d, stat_resp_q, stat_resp_d;
   logic        wr_issue;

   always_comb begin
      wr_issue    = req_issue & req_head[MEM_REQ_Q_W-1];
      stat_wr_d   = stat_wr_q   + {31'd0, wr_issue};
      stat_rd_d   = stat_rd_q   + {31'd0, rd_issue};
      stat_resp_d = stat_resp_q + {31'd0, resp_pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_wr_q   <= '0;
         stat_rd_q   <= '0;
         stat_resp_q <= '0;
      end else begin
         stat_wr_q   <= stat_wr_d;
         stat_rd_q   <= stat_rd_d;
         stat_resp_q <= stat_resp_d;
      end
   end

   assign stat_wr   = stat_wr_q;
   assign stat_rd   = stat_rd_q;
   assign stat_resp = stat_resp_q;
`else
   assign stat_wr   = '0;
   assign stat_rd   = '0;
   assign stat_resp = '0;
`endif

endmodule

// File: tb/tb_ami_port_buffer.sv
// Bench for ami_port_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_ami_port_buffer;
   import AMITypes::*;

   localparam int RQ = 8;
   localparam int RS = 8;
`ifdef AMI_PORT_BUFFER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      logic        w;
      logic [63:0] a;
      logic [511:0] d;
   } mreq_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   MemReq       app_req_in;
   logic        app_req_grant_out;
   MemResp      app_resp_out;
   logic        app_resp_grant_in;
   MemReq       ami_req_out;
   logic        ami_req_grant_in;
   MemResp      ami_resp_in;
   logic        ami_resp_grant_out;
   logic [3:0]  req_q_count;
   logic [3:0]  read_credits;
   logic [31:0] stat_wr, stat_rd, stat_resp;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: request queue, response queue, AMI-side pending reads, credit count.
   mreq_t        mq[$];
   logic [511:0] mr[$];
   logic [511:0] ami_pend[$];
   int           m_cred, m_wr, m_rd, m_resp;
   int           ami_pct;
   logic         e_app_gnt, e_ami_vld, e_resp_gnt, e_resp_vld;

   ami_port_buffer dut (
      .clk                (clk),
      .rst                (rst),
      .enable             (enable),
      .app_req_in         (app_req_in),
      .app_req_grant_out  (app_req_grant_out),
      .app_resp_out       (app_resp_out),
      .app_resp_grant_in  (app_resp_grant_in),
      .ami_req_out        (ami_req_out),
      .ami_req_grant_in   (ami_req_grant_in),
      .ami_resp_in        (ami_resp_in),
      .ami_resp_grant_out (ami_resp_grant_out),
      .req_q_count        (req_q_count),
      .read_credits       (read_credits),
      .stat_wr            (stat_wr),
      .stat_rd            (stat_rd),
      .stat_resp          (stat_resp)
   );

   always #5 clk = ~clk;

   function automatic logic [511:0] rd_data(input logic [63:0] a);
      return {448'd0, 64'hBEEF0000 + a};
   endfunction

   function automatic void model_reset();
      mq.delete(); mr.delete(); ami_pend.delete();
      m_cred = RS; m_wr = 0; m_rd = 0; m_resp = 0;
   endfunction

   function automatic void model_eval();
      e_app_gnt  = !rst && app_req_in.valid && enable && (mq.size() < RQ);
      e_ami_vld  = enable && (mq.size() > 0) && (mq[0].w || m_cred != 0);
      e_resp_gnt = !rst && ami_resp_in.valid && (mr.size() < RS);
      e_resp_vld = mr.size() > 0;
   endfunction

   task automatic set_req(input logic v, input logic w, input logic [63:0] a, input logic [511:0] d);
      app_req_in.valid   = v;
      app_req_in.isWrite = w;
      app_req_in.addr    = a;
      app_req_in.data    = d;
   endtask

   // Advance the model over one clock edge, then act as AMI returning pending reads in order.
   task automatic step();
      mreq_t h;
      logic  iss, pop;
      model_eval();
      iss = e_ami_vld && ami_req_grant_in;
      pop = e_resp_vld && app_resp_grant_in;
      if (iss) begin
         h = mq.pop_front();
         if (h.w) m_wr++;
         else begin m_rd++; m_cred--; ami_pend.push_back(rd_data(h.a)); end
      end
      if (pop) begin void'(mr.pop_front()); m_cred++; m_resp++; end
      if (e_resp_gnt) begin mr.push_back(ami_resp_in.data); void'(ami_pend.pop_front()); end
      if (e_app_gnt) mq.push_back('{app_req_in.isWrite, app_req_in.addr, app_req_in.data});
      @(posedge clk); #1;
      ami_resp_in.valid = (ami_pend.size() > 0) && ($urandom_range(0, 99) < ami_pct);
      ami_resp_in.data  = (ami_pend.size() > 0) ? ami_pend[0] : '0;
   endtask

   task automatic test_reset();
      #2;
      set_req(1'b1, 1'b1, 64'h40, '1);
      enable = 1'b1; ami_resp_in.valid = 1'b1;
      #1;
      n_tests++; if (app_req_grant_out !== 1'b0) begin n_fail++; $display("FAIL reset_app_gnt: got %0b want 0", app_req_grant_out); end
      n_tests++; if (ami_req_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_ami_vld: got %0b want 0", ami_req_out.valid); end
      n_tests++; if (ami_resp_grant_out !== 1'b0) begin n_fail++; $display("FAIL reset_resp_gnt: got %0b want 0", ami_resp_grant_out); end
      n_tests++; if (app_resp_out.valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_vld: got %0b want 0", app_resp_out.valid); end
      n_tests++; if (req_q_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", req_q_count); end
      n_tests++; if (read_credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits: got %0d want 8", read_credits); end
      n_tests++; if ({stat_wr, stat_rd, stat_resp} !== 96'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0", stat_wr, stat_rd, stat_resp); end
      app_req_in = '0; ami_resp_in = '0; enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      step();
   endtask

   task automatic test_writes();
      enable = 1'b1; ami_req_grant_in = 1'b1; app_resp_grant_in = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c < 8) set_req(1'b1, 1'b1, 64'(c * 64), {480'd0, 32'hDEAD0000 + 32'(c)});
         else app_req_in = '0;
         #1;
         if (c < 8) begin
            n_tests++; if (app_req_grant_out !== 1'b1) begin n_fail++; $display("FAIL wr_grant c=%0d: got %0b want 1", c, app_req_grant_out); end
         end
         if (c >= 1 && c <= 8) begin
            n_tests++;
            if ({ami_req_out.valid, ami_req_out.isWrite, ami_req_out.addr, ami_req_out.data} !==
                {2'b11, 64'((c - 1) * 64), {480'd0, 32'hDEAD0000 + 32'(c - 1)}}) begin
               n_fail++; $display("FAIL wr_issue c=%0d: got v=%0b addr=%0h data=%0h want addr=%0h", c,
                                  ami_req_out.valid, ami_req_out.addr, ami_req_out.data[31:0], (c - 1) * 64);
            end
         end else begin
            n_tests++; if (ami_req_out.valid !== 1'b0) begin n_fail++; $display("FAIL wr_idle c=%0d: got %0b want 0", c, ami_req_out.valid); end
         end
         step();
      end
      #1;
      n_tests++; if (stat_wr !== (STATS ? 32'd8 : 32'd0)) begin n_fail++; $display("FAIL wr_stat: got %0d want %0d", stat_wr, STATS ? 8 : 0); end
   endtask

   task automatic test_req_full();
      int n, iss;
      n = 0; iss = 0;
      ami_req_grant_in = 1'b0;
      for (int c = 0; c < 12; c++) begin
         set_req(1'b1, 1'b1, 64'h1000 + 64'(n * 64), 512'(n));
         #1;
         if (app_req_grant_out) n++;
         step();
      end
      set_req(1'b1, 1'b1, 64'h1000 + 64'(n * 64), 512'(n));
      #1;
      n_tests++; if (n !== 8) begin n_fail++; $display("FAIL full_granted: got %0d want 8", n); end
      n_tests++; if (req_q_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", req_q_count); end
      n_tests++; if (app_req_grant_out !== 1'b0) begin n_fail++; $display("FAIL full_gnt: got %0b want 0", app_req_grant_out); end
      ami_req_grant_in = 1'b1;
      #1;
      n_tests++; if (app_req_grant_out !== 1'b0) begin n_fail++; $display("FAIL full_no_passthru: got %0b want 0", app_req_grant_out); end
      for (int c = 0; c < 30 && iss < 10; c++) begin
         if (n < 10) set_req(1'b1, 1'b1, 64'h1000 + 64'(n * 64), 512'(n));
         else app_req_in = '0;
         #1;
         if (ami_req_out.valid) begin
            n_tests++; if (ami_req_out.addr !== 64'h1000 + 64'(iss * 64)) begin n_fail++; $display("FAIL full_drain_order %0d: got %0h want %0h", iss, ami_req_out.addr, 64'h1000 + 64'(iss * 64)); end
            iss++;
         end
         if (app_req_grant_out) n++;
         step();
      end
      app_req_in = '0;
      n_tests++; if (iss !== 10) begin n_fail++; $display("FAIL full_drain_cnt: got %0d want 10", iss); end
      n_tests++; if (n !== 10) begin n_fail++; $display("FAIL full_accept_cnt: got %0d want 10", n); end
   endtask

   task automatic test_credit_stall();
      int n, iss, got;
      n = 0; iss = 0; got = 1;
      ami_pct = 100; ami_req_grant_in = 1'b1; app_resp_grant_in = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (n < 9) set_req(1'b1, 1'b0, 64'(n), '0);
         else app_req_in = '0;
         #1;
         if (ami_req_out.valid) iss++;
         if (app_req_grant_out) n++;
         step();
      end
      app_req_in = '0;
      #1;
      n_tests++; if (iss !== 8) begin n_fail++; $display("FAIL cs_issued: got %0d want 8", iss); end
      n_tests++; if (read_credits !== 4'd0) begin n_fail++; $display("FAIL cs_credits0: got %0d want 0", read_credits); end
      n_tests++; if (ami_req_out.valid !== 1'b0) begin n_fail++; $display("FAIL cs_stalled: got %0b want 0", ami_req_out.valid); end
      n_tests++; if (req_q_count !== 4'd1) begin n_fail++; $display("FAIL cs_count: got %0d want 1", req_q_count); end
      n_tests++; if (app_resp_out.data !== rd_data(0)) begin n_fail++; $display("FAIL cs_head: got %0h want %0h", app_resp_out.data[63:0], rd_data(0)); end
      app_resp_grant_in = 1'b1;
      #1;
      step();
      app_resp_grant_in = 1'b0;
      #1;
      n_tests++; if ({ami_req_out.valid, ami_req_out.addr} !== {1'b1, 64'd8}) begin n_fail++; $display("FAIL cs_9th: got v=%0b addr=%0h want v=1 addr=8", ami_req_out.valid, ami_req_out.addr); end
      n_tests++; if (read_credits !== 4'd1) begin n_fail++; $display("FAIL cs_credit1: got %0d want 1", read_credits); end
      step();
      #1;
      n_tests++; if (read_credits !== 4'd0) begin n_fail++; $display("FAIL cs_credit_back0: got %0d want 0", read_credits); end
      app_resp_grant_in = 1'b1;
      for (int c = 0; c < 30 && got < 9; c++) begin
         #1;
         if (app_resp_out.valid) begin
            n_tests++; if (app_resp_out.data !== rd_data(64'(got))) begin n_fail++; $display("FAIL cs_order %0d: got %0h want %0h", got, app_resp_out.data[63:0], rd_data(64'(got))); end
            got++;
         end
         step();
      end
      app_resp_grant_in = 1'b0;
      #1;
      n_tests++; if (got !== 9) begin n_fail++; $display("FAIL cs_resp_cnt: got %0d want 9", got); end
      n_tests++; if (read_credits !== 4'd8) begin n_fail++; $display("FAIL cs_credits_full: got %0d want 8", read_credits); end
   endtask

   task automatic test_simul_credit();
      bit got;
      got = 1'b0;
      app_resp_grant_in = 1'b0; ami_req_grant_in = 1'b1; ami_pct = 100;
      set_req(1'b1, 1'b0, 64'd3, '0);
      #1; step();
      app_req_in = '0;
      for (int c = 0; c < 10 && !app_resp_out.valid; c++) begin step(); #1; end
      n_tests++; if (app_resp_out.valid !== 1'b1) begin n_fail++; $display("FAIL sc_resp_arrive: got %0b want 1", app_resp_out.valid); end
      n_tests++; if (read_credits !== 4'd7) begin n_fail++; $display("FAIL sc_credits7: got %0d want 7", read_credits); end
      ami_req_grant_in = 1'b0;
      set_req(1'b1, 1'b0, 64'd4, '0);
      #1; step();
      app_req_in = '0;
      ami_req_grant_in = 1'b1; app_resp_grant_in = 1'b1;
      #1;
      n_tests++; if ({ami_req_out.valid, ami_req_out.addr} !== {1'b1, 64'd4}) begin n_fail++; $display("FAIL sc_issue: got v=%0b addr=%0h want v=1 addr=4", ami_req_out.valid, ami_req_out.addr); end
      n_tests++; if (app_resp_out.data !== rd_data(3)) begin n_fail++; $display("FAIL sc_data3: got %0h want %0h", app_resp_out.data[63:0], rd_data(3)); end
      step();
      ami_req_grant_in = 1'b0; app_resp_grant_in = 1'b0;
      #1;
      n_tests++; if (read_credits !== 4'd7) begin n_fail++; $display("FAIL sc_unchanged: got %0d want 7", read_credits); end
      app_resp_grant_in = 1'b1;
      for (int c = 0; c < 10 && !got; c++) begin
         #1;
         if (app_resp_out.valid) begin
            got = 1'b1;
            n_tests++; if (app_resp_out.data !== rd_data(4)) begin n_fail++; $display("FAIL sc_data4: got %0h want %0h", app_resp_out.data[63:0], rd_data(4)); end
         end
         step();
      end
      app_resp_grant_in = 1'b0;
      #1;
      n_tests++; if (read_credits !== 4'd8) begin n_fail++; $display("FAIL sc_credits8: got %0d want 8 (resp seen %0b)", read_credits, got); end
   endtask

   task automatic test_enable();
      int got, bad, iss;
      got = 0; bad = 0; iss = 0;
      enable = 1'b1; ami_pct = 0; ami_req_grant_in = 1'b1; app_resp_grant_in = 1'b0;
      for (int i = 0; i < 2; i++) begin set_req(1'b1, 1'b0, 64'h20 + 64'(i), '0); #1; step(); end
      app_req_in = '0;
      #1; step(); step();
      ami_req_grant_in = 1'b0;
      for (int i = 0; i < 3; i++) begin set_req(1'b1, 1'b1, 64'h30 + 64'(i), 512'(i)); #1; step(); end
      app_req_in = '0;
      #1;
      n_tests++; if (req_q_count !== 4'd3) begin n_fail++; $display("FAIL en_queued: got %0d want 3", req_q_count); end
      enable = 1'b0; ami_req_grant_in = 1'b1; ami_pct = 100; app_resp_grant_in = 1'b1;
      set_req(1'b1, 1'b1, 64'h99, '0);
      for (int c = 0; c < 10; c++) begin
         #1;
         if (app_req_grant_out || ami_req_out.valid) bad++;
         if (app_resp_out.valid) begin
            n_tests++; if (app_resp_out.data !== rd_data(64'h20 + 64'(got))) begin n_fail++; $display("FAIL en_drain %0d: got %0h want %0h", got, app_resp_out.data[63:0], rd_data(64'h20 + 64'(got))); end
            got++;
         end
         step();
      end
      app_req_in = '0;
      #1;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL en_blocked: got %0d active cycles want 0", bad); end
      n_tests++; if (got !== 2) begin n_fail++; $display("FAIL en_resp_cnt: got %0d want 2", got); end
      n_tests++; if (req_q_count !== 4'd3) begin n_fail++; $display("FAIL en_retained: got %0d want 3", req_q_count); end
      enable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (ami_req_out.valid) begin
            n_tests++; if ({ami_req_out.isWrite, ami_req_out.addr} !== {1'b1, 64'h30 + 64'(iss)}) begin n_fail++; $display("FAIL en_issue %0d: got w=%0b addr=%0h want w=1 addr=%0h", iss, ami_req_out.isWrite, ami_req_out.addr, 64'h30 + 64'(iss)); end
            iss++;
         end
         step();
      end
      n_tests++; if (iss !== 3) begin n_fail++; $display("FAIL en_issue_cnt: got %0d want 3", iss); end
   endtask

   task automatic test_random();
      ami_pct = 70;
      for (int c = 0; c < 400; c++) begin
         enable = ($urandom_range(0, 9) != 0);
         set_req($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), {32'd0, $urandom()}, {16{$urandom()}});
         ami_req_grant_in  = ($urandom_range(0, 3) != 0);
         app_resp_grant_in = ($urandom_range(0, 3) != 0);
         #1;
         model_eval();
         n_tests++; if (app_req_grant_out !== e_app_gnt) begin n_fail++; $display("FAIL rnd_app_gnt c=%0d: got %0b want %0b", c, app_req_grant_out, e_app_gnt); end
         n_tests++; if (ami_req_out.valid !== e_ami_vld) begin n_fail++; $display("FAIL rnd_ami_vld c=%0d: got %0b want %0b", c, ami_req_out.valid, e_ami_vld); end
         if (e_ami_vld) begin
            n_tests++; if ({ami_req_out.isWrite, ami_req_out.addr, ami_req_out.data} !== {mq[0].w, mq[0].a, mq[0].d}) begin n_fail++; $display("FAIL rnd_ami_head c=%0d: got addr=%0h want %0h", c, ami_req_out.addr, mq[0].a); end
         end
         n_tests++; if (ami_resp_grant_out !== e_resp_gnt) begin n_fail++; $display("FAIL rnd_resp_gnt c=%0d: got %0b want %0b", c, ami_resp_grant_out, e_resp_gnt); end
         n_tests++; if (app_resp_out.valid !== e_resp_vld) begin n_fail++; $display("FAIL rnd_resp_vld c=%0d: got %0b want %0b", c, app_resp_out.valid, e_resp_vld); end
         if (e_resp_vld) begin
            n_tests++; if (app_resp_out.data !== mr[0]) begin n_fail++; $display("FAIL rnd_resp_data c=%0d: got %0h want %0h", c, app_resp_out.data[63:0], mr[0][63:0]); end
         end
         n_tests++; if (req_q_count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, req_q_count, mq.size()); end
         n_tests++; if (read_credits !== 4'(m_cred)) begin n_fail++; $display("FAIL rnd_credits c=%0d: got %0d want %0d", c, read_credits, m_cred); end
         n_tests++;
         if ({stat_wr, stat_rd, stat_resp} !== (STATS ? {32'(m_wr), 32'(m_rd), 32'(m_resp)} : 96'd0)) begin
            n_fail++; $display("FAIL rnd_stats c=%0d: got %0d/%0d/%0d want %0d/%0d/%0d (stats %0b)", c, stat_wr, stat_rd, stat_resp, m_wr, m_rd, m_resp, STATS);
         end
         step();
      end
   endtask

   task automatic test_mid_reset();
      int bad;
      bad = 0;
      enable = 1'b1; ami_pct = 0; ami_req_grant_in = 1'b1; app_resp_grant_in = 1'b0;
      for (int i = 0; i < 3; i++) begin set_req(1'b1, 1'b0, 64'h50 + 64'(i), '0); #1; step(); end
      ami_req_grant_in = 1'b0;
      set_req(1'b1, 1'b1, 64'h60, '0);
      #1; step();
      ami_resp_in.valid = 1'b1; ami_resp_in.data = rd_data(64'h50);
      #2;
      rst = 1'b1;
      #1;
      n_tests++; if (app_req_grant_out !== 1'b0) begin n_fail++; $display("FAIL mr_app_gnt: got %0b want 0", app_req_grant_out); end
      n_tests++; if (ami_req_out.valid !== 1'b0) begin n_fail++; $display("FAIL mr_ami_vld: got %0b want 0", ami_req_out.valid); end
      n_tests++; if (ami_resp_grant_out !== 1'b0) begin n_fail++; $display("FAIL mr_resp_gnt: got %0b want 0", ami_resp_grant_out); end
      n_tests++; if (app_resp_out.valid !== 1'b0) begin n_fail++; $display("FAIL mr_resp_vld: got %0b want 0", app_resp_out.valid); end
      n_tests++; if (req_q_count !== 4'd0) begin n_fail++; $display("FAIL mr_count: got %0d want 0", req_q_count); end
      n_tests++; if (read_credits !== 4'd8) begin n_fail++; $display("FAIL mr_credits: got %0d want 8", read_credits); end
      n_tests++; if ({stat_wr, stat_rd, stat_resp} !== 96'd0) begin n_fail++; $display("FAIL mr_stats: got %0d/%0d/%0d want 0", stat_wr, stat_rd, stat_resp); end
      model_reset();
      app_req_in = '0; ami_resp_in = '0;
      step();
      rst = 1'b0;
      app_resp_grant_in = 1'b1; ami_req_grant_in = 1'b1; ami_pct = 100;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (app_resp_out.valid) bad++;
         step();
      end
      #1;
      n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL mr_stale_resp: got %0d deliveries want 0", bad); end
      n_tests++; if (read_credits !== 4'd8) begin n_fail++; $display("FAIL mr_credits_after: got %0d want 8", read_credits); end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0;
      app_req_in = '0; app_resp_grant_in = 1'b0; ami_req_grant_in = 1'b0; ami_resp_in = '0;
      ami_pct = 100;
      model_reset();
      test_reset();
      test_writes();
      test_req_full();
      test_credit_stall();
      test_simul_credit();
      test_enable();
      test_random();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ami_port_buffer.md
# ami_port_buffer

Per-port elastic buffer between one application memory port and the corresponding `mem_req_in`/`mem_resp_out` port of `AmorphOSMem`. It decouples the app from AMI back-pressure with a request FIFO. It also buffers returning read data in a response FIFO, and issues a read downstream only when response space is guaranteed, so the response path never overflows. One instance is placed per (app, port) pair, directly upstream of `AmorphOSMem`.

## Interface
Parameters:
- `LOG_REQ_Q_SIZE`, default 3: request FIFO depth is 2^N entries.
- `LOG_RESP_Q_SIZE`, default 3: response FIFO depth is 2^N entries. This also sets the read-credit limit.

Ports:
- `clk`, in, 1: the single clock for the block.
- `rst`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: port enable. Intended to be tied to the AMI `port_enable[a][p]` signal.
- `app_req_in`, in, MemReq: request from the app, with fields `valid`, `isWrite`, `addr`, `data`.
- `app_req_grant_out`, out, 1: the app request is accepted this cycle.
- `app_resp_out`, out, MemResp: response to the app, with fields `valid` and `data`.
- `app_resp_grant_in`, in, 1: the app consumes `app_resp_out` this cycle.
- `ami_req_out`, out, MemReq: request to `AmorphOSMem` `mem_req_in`.
- `ami_req_grant_in`, in, 1: AMI accepted `ami_req_out` this cycle.
- `ami_resp_in`, in, MemResp: response from AMI `mem_resp_out`.
- `ami_resp_grant_out`, out, 1: the block consumes `ami_resp_in` this cycle.
- `req_q_count`, out, LOG_REQ_Q_SIZE+1: current request FIFO occupancy.
- `read_credits`, out, LOG_RESP_Q_SIZE+1: number of unreserved response slots.
- `stat_wr`, `stat_rd`, `stat_resp`, out, 32 each: statistics counters (see Configuration).

## Operation
- **Request accept.** `app_req_grant_out = app_req_in.valid & enable & !req_full`. On grant, the whole request is written into the request FIFO at the clock edge.
- **Request issue.** `ami_req_out` carries the FIFO head. Its `valid = enable & !req_empty & (head.isWrite | read_credits != 0)`. The head is popped on `ami_req_out.valid & ami_req_grant_in`.
- **Credits.**
  - The counter resets to 2^LOG_RESP_Q_SIZE.
  - It decrements by 1 when a read is issued.
  - It increments by 1 when the app pops a response.
  - If both happen in the same cycle, it is unchanged.
  - The credit count never goes below 0 or above 2^LOG_RESP_Q_SIZE.
- **Response capture.** `ami_resp_grant_out = ami_resp_in.valid & !resp_full`. By construction of the credits, `resp_full` is never seen with a valid response.
- **Response delivery.** `app_resp_out.valid = !resp_empty`, and `app_resp_out.data` is the FIFO head. The head is popped on `app_resp_grant_in & app_resp_out.valid`.
- **Order.** Requests are strictly in order. Responses are returned in arrival order; AMI guarantees per-port in-order completion.
- **Full FIFO.** A full request FIFO refuses a new request even if it is popped in the same cycle. There is no same-cycle pass-through of a freed slot.
- **Empty FIFO.** An empty FIFO drives `valid = 0`; the data field holds its last value and is don't-care.
- **Pointers.** Pointers are LOG+1 bits wide and wrap naturally. Full means the MSBs differ and the rest match; empty means the pointers are equal.
- **enable low.**
  - Accept and issue are blocked.
  - Queued requests are retained.
  - Response capture and delivery continue, so in-flight reads drain.
- **Writes** produce no response and consume no credit.

## Timing
- **Reset values** (all asynchronous):
  - `app_req_grant_out=0`, `ami_req_out.valid=0`, `ami_resp_grant_out=0`, `app_resp_out.valid=0`.
  - `req_q_count=0`, `read_credits=2^LOG_RESP_Q_SIZE`, `stat_*=0`.
  - Both FIFOs are empty.
- **Reset mid-operation** discards all queued requests and responses immediately. Outstanding AMI reads are the system's responsibility; AMI is reset together with this block.
- **Grant outputs** are combinational from registered state plus the current `valid` or `enable` inputs. They never depend on the opposite-side grant.
- **Latency.**
  - A request granted at edge N appears on `ami_req_out` in cycle N+1 at the earliest.
  - A response captured at edge M appears on `app_resp_out` in cycle M+1.
- **Throughput** is one request and one response per cycle, sustained.

## Configuration
- Macro `AMI_PORT_BUFFER_STATS_EN`.
- **Defined:** three 32-bit wrapping counters are compiled in.
  - `stat_wr` increments on each write issued to AMI.
  - `stat_rd` increments on each read issued to AMI.
  - `stat_resp` increments on each response delivered to the app.
- **Undefined:** no counter logic is compiled; the `stat_*` ports are driven constant 0.

## Structure
- `MemReq`, `MemResp` and the default queue sizes come from the `AMITypes` package. Add `AMI_PORT_BUF_LOG_Q_DEFAULT` (value 3) to that package.
- Sub-module `ami_port_fifo`: a synchronous FIFO with parameters `WIDTH` and `LOG_DEPTH`, and outputs `full`, `empty` and `count`. It is instantiated twice: once for requests at MemReq width minus `valid`, and once for responses at data width.
- Credit counter, grant logic and stats live in the top module.

## Test plan
- **Writes with AMI always granting:** 8 writes, addr i*64, data 'hDEAD0000+i, `ami_req_grant_in=1` → all 8 appear on `ami_req_out` in order, one per cycle starting 1 cycle after the first grant; `stat_wr=8`.
- **Request FIFO full:** `ami_req_grant_in=0`, 10 writes offered → exactly 8 granted, `req_q_count=8`, grant stays low. Release → the 8 drain in order and the remaining 2 are then accepted.
- **Credit stall:** 9 reads offered, AMI returns data but `app_resp_grant_in=0` → 8 reads issued, 9th stalled with `read_credits=0`. One app pop → 9th issued the next cycle.
- **Simultaneous credit events:** a read is issued and the app pops a response in the same cycle → `read_credits` unchanged. Response data 'hBEEF0003 is delivered in order.
- **enable toggle:** `enable=0` with 3 queued writes and 2 in-flight reads → no issue and no grant, both responses still delivered. `enable=1` → the 3 writes issue.
- **Mid-traffic reset:** `rst` pulsed asynchronously mid-traffic → all outputs at reset values within the same cycle, `read_credits=8`, no stale response is delivered after release.
